// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared state encodings and blanking constants for the display scheduler
package disp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NOTE = 2'd1,
        MSG  = 2'd2
    } disp_state_e;

    localparam logic [3:0] BLANK_ALL  = 4'b1111;
    localparam logic [3:0] BLANK_NONE = 4'b0000;

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - free-running 0..TICK_DIV-1 counter emitting a one-cycle tick at wrap
module tick_prescaler #(
    parameter int TICK_DIV = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == CW'(TICK_DIV - 1));

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seg_display_scheduler.sv
// rtl/seg_display_scheduler.sv - arbitrates the 4-digit 7-seg display between live note and timed overlay messages
module seg_display_scheduler
    import disp_pkg::*;
#(
    parameter int TICK_DIV = 100000,
    parameter int HOLD_MS  = 1500,
    parameter int MIN_MS   = 200,
    parameter int BLINK_MS = 250
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        note_valid,
    input  logic [15:0] note_val,
    input  logic        msg_valid,
    input  logic [15:0] msg_data,
    input  logic        msg_dp,
    input  logic        msg_blink,
    output logic        msg_ready,
    output logic [3:0]  val0,
    output logic [3:0]  val1,
    output logic [3:0]  val2,
    output logic [3:0]  val3,
    output logic        dp_out,
    output logic [3:0]  blank,
    output logic        msg_active
);

    localparam int EW = $clog2(HOLD_MS + 1);
    localparam int BW = (BLINK_MS > 1) ? $clog2(BLINK_MS + 1) : 1;

    disp_state_e   state_q, state_d;
    logic [EW-1:0] elapsed_q, elapsed_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          phase_q, phase_d;
    logic [15:0]   mdata_q, mdata_d;
    logic          mdp_q, mdp_d;
    logic          mblink_q, mblink_d;
    logic [15:0]   val_q, val_d;
    logic          dp_q, dp_d;
    logic [3:0]    blank_q, blank_d;
    logic          ready_q, ready_d;
    logic          active_q, active_d;
    logic          tick;
    logic          accept;

    assign accept = msg_valid && ready_q;

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (accept),
        .tick  (tick)
    );

    always_comb begin
        state_d   = state_q;
        elapsed_d = elapsed_q;
        bcnt_d    = bcnt_q;
        phase_d   = phase_q;
        mdata_d   = mdata_q;
        mdp_d     = mdp_q;
        mblink_d  = mblink_q;
        val_d     = val_q;
        dp_d      = 1'b0;
        blank_d   = BLANK_ALL;

        case (state_q)
            IDLE: if (note_valid) state_d = NOTE;
            NOTE: if (!note_valid) state_d = IDLE;
            MSG: begin
                if (tick) begin
                    elapsed_d = elapsed_q + EW'(1);
                    if (bcnt_q == BW'(BLINK_MS - 1)) begin
                        bcnt_d  = '0;
                        phase_d = ~phase_q;
                    end else begin
                        bcnt_d = bcnt_q + BW'(1);
                    end
                    // Exit on the edge where elapsed reaches HOLD_MS so the message occupies exactly HOLD_MS ms.
                    if (elapsed_d == EW'(HOLD_MS)) begin
                        state_d   = note_valid ? NOTE : IDLE;
                        elapsed_d = '0;
                        bcnt_d    = '0;
                        phase_d   = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A new accept overrides any expiry on the same edge.
        if (accept) begin
            state_d   = MSG;
            elapsed_d = '0;
            bcnt_d    = '0;
            phase_d   = 1'b0;
            mdata_d   = msg_data;
            mdp_d     = msg_dp;
            mblink_d  = msg_blink;
        end

        case (state_d)
            NOTE: begin
                val_d   = note_val;
                blank_d = BLANK_NONE;
            end
            MSG: begin
                val_d   = mdata_d;
                dp_d    = mdp_d;
                blank_d = (mblink_d && phase_d) ? BLANK_ALL : BLANK_NONE;
            end
            default: ;
        endcase

        ready_d  = !((state_d == MSG) && (elapsed_d < EW'(MIN_MS)));
        active_d = (state_d == MSG);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            elapsed_q <= '0;
            bcnt_q    <= '0;
            phase_q   <= 1'b0;
            mdata_q   <= '0;
            mdp_q     <= 1'b0;
            mblink_q  <= 1'b0;
            val_q     <= '0;
            dp_q      <= 1'b0;
            blank_q   <= BLANK_ALL;
            ready_q   <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            elapsed_q <= elapsed_d;
            bcnt_q    <= bcnt_d;
            phase_q   <= phase_d;
            mdata_q   <= mdata_d;
            mdp_q     <= mdp_d;
            mblink_q  <= mblink_d;
            val_q     <= val_d;
            dp_q      <= dp_d;
            blank_q   <= blank_d;
            ready_q   <= ready_d;
            active_q  <= active_d;
        end
    end

    assign val0       = val_q[3:0];
    assign val1       = val_q[7:4];
    assign val2       = val_q[11:8];
    assign val3       = val_q[15:12];
    assign dp_out     = dp_q;
    assign blank      = blank_q;
    assign msg_ready  = ready_q;
    assign msg_active = active_q;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// tb/tb_seg_display_scheduler.sv - scoreboard bench for the 7-seg display scheduler
module tb_seg_display_scheduler;

    localparam int TD = 4;
    localparam int HM = 10;
    localparam int MN = 3;
    localparam int BM = 2;

    localparam logic [22:0] M_ALL  = 23'h7F_FFFF;
    localparam logic [22:0] M_IDLE = 23'h6F_0000;

    typedef struct {
        string       tag;
        logic [22:0] exp;
        logic [22:0] mask;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        note_valid;
    logic [15:0] note_val;
    logic        msg_valid;
    logic [15:0] msg_data;
    logic        msg_dp;
    logic        msg_blink;
    logic        msg_ready;
    logic [3:0]  val0, val1, val2, val3;
    logic        dp_out;
    logic [3:0]  blank;
    logic        msg_active;
    logic [22:0] obs;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    seg_display_scheduler #(
        .TICK_DIV (TD),
        .HOLD_MS  (HM),
        .MIN_MS   (MN),
        .BLINK_MS (BM)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .note_valid (note_valid),
        .note_val   (note_val),
        .msg_valid  (msg_valid),
        .msg_data   (msg_data),
        .msg_dp     (msg_dp),
        .msg_blink  (msg_blink),
        .msg_ready  (msg_ready),
        .val0       (val0),
        .val1       (val1),
        .val2       (val2),
        .val3       (val3),
        .dp_out     (dp_out),
        .blank      (blank),
        .msg_active (msg_active)
    );

    assign obs = {msg_ready, msg_active, dp_out, blank, val3, val2, val1, val0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [22:0] pk(input logic r, input logic a, input logic d,
                                       input logic [3:0] b, input logic [15:0] v);
        return {r, a, d, b, v};
    endfunction

    task automatic check_eq(input string tag, input logic [22:0] got, input logic [22:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic cyc(input string tag, input logic [22:0] e, input logic [22:0] m);
        exp_t x;
        x.tag  = tag;
        x.exp  = e;
        x.mask = m;
        sb.push_back(x);
        @(posedge clk);
        @(negedge clk);
        x = sb.pop_front();
        check_eq(x.tag, obs & x.mask, x.exp & x.mask);
    endtask

    // k counts cycles after the accept edge; k=0 is the first cycle showing the message.
    task automatic msg_cyc(input string tag, input int k, input logic [15:0] d,
                           input logic dp, input logic bl);
        logic       rdy;
        logic [3:0] b;
        rdy = (k >= MN * TD);
        b   = (bl && (((k / (BM * TD)) % 2) == 1)) ? 4'hF : 4'h0;
        cyc(tag, pk(rdy, 1'b1, dp, b, d), M_ALL);
    endtask

    task automatic accept_msg(input string tag, input logic [15:0] d, input logic dp, input logic bl);
        msg_valid = 1'b1;
        msg_data  = d;
        msg_dp    = dp;
        msg_blink = bl;
        msg_cyc(tag, 0, d, dp, bl);
        msg_valid = 1'b0;
        msg_data  = 16'hFFFF;
        msg_dp    = 1'b0;
        msg_blink = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        note_valid = 1'b0;
        note_val   = 16'h0000;
        msg_valid  = 1'b0;
        msg_data   = 16'h0000;
        msg_dp     = 1'b0;
        msg_blink  = 1'b0;

        cyc("rst0", pk(1'b0, 1'b0, 1'b0, 4'hF, 16'h0000), M_ALL);
        cyc("rst1", pk(1'b0, 1'b0, 1'b0, 4'hF, 16'h0000), M_ALL);
        reset = 1'b0;
        cyc("ready_after_rst", pk(1'b1, 1'b0, 1'b0, 4'hF, 16'h0000), M_IDLE);

        note_valid = 1'b1;
        note_val   = 16'h0C4A;
        cyc("note_on", pk(1'b1, 1'b0, 1'b0, 4'h0, 16'h0C4A), M_ALL);
        note_val = 16'h1234;
        cyc("note_resample", pk(1'b1, 1'b0, 1'b0, 4'h0, 16'h1234), M_ALL);
        note_valid = 1'b0;
        cyc("note_off", pk(1'b1, 1'b0, 1'b0, 4'hF, 16'h0000), M_IDLE);

        note_valid = 1'b1;
        note_val   = 16'h0C4A;
        cyc("note_again", pk(1'b1, 1'b0, 1'b0, 4'h0, 16'h0C4A), M_ALL);
        accept_msg("m1", 16'h0005, 1'b1, 1'b0);
        for (int k = 1; k < HM * TD; k++) begin
            if (k == 15) note_valid = 1'b0;
            if (k == 25) note_valid = 1'b1;
            msg_cyc("m1", k, 16'h0005, 1'b1, 1'b0);
        end
        cyc("m1_end_note", pk(1'b1, 1'b0, 1'b0, 4'h0, 16'h0C4A), M_ALL);

        accept_msg("m2", 16'h1111, 1'b0, 1'b0);
        for (int k = 1; k < 9; k++) msg_cyc("m2", k, 16'h1111, 1'b0, 1'b0);
        msg_data  = 16'h2222;
        msg_valid = 1'b1;
        for (int k = 9; k < MN * TD + 1; k++) msg_cyc("m2_early_offer", k, 16'h1111, 1'b0, 1'b0);
        accept_msg("m3_accept_3ms", 16'h2222, 1'b0, 1'b0);
        for (int k = 1; k < HM * TD; k++) msg_cyc("m3", k, 16'h2222, 1'b0, 1'b0);
        accept_msg("m4_accept_at_expiry", 16'h3333, 1'b1, 1'b0);
        for (int k = 1; k < HM * TD; k++) msg_cyc("m4", k, 16'h3333, 1'b1, 1'b0);
        cyc("m4_end_note", pk(1'b1, 1'b0, 1'b0, 4'h0, 16'h0C4A), M_ALL);

        note_valid = 1'b0;
        cyc("idle_before_blink", pk(1'b1, 1'b0, 1'b0, 4'hF, 16'h0000), M_IDLE);
        accept_msg("blink", 16'h0007, 1'b0, 1'b1);
        for (int k = 1; k < HM * TD; k++) msg_cyc("blink", k, 16'h0007, 1'b0, 1'b1);
        cyc("blink_end_idle", pk(1'b1, 1'b0, 1'b0, 4'hF, 16'h0000), M_IDLE);

        note_valid = 1'b1;
        accept_msg("m5", 16'h0009, 1'b1, 1'b0);
        for (int k = 1; k < 20; k++) msg_cyc("m5", k, 16'h0009, 1'b1, 1'b0);
        reset      = 1'b1;
        note_valid = 1'b0;
        #1;
        check_eq("rst_async", obs, pk(1'b0, 1'b0, 1'b0, 4'hF, 16'h0000));
        cyc("rst_mid0", pk(1'b0, 1'b0, 1'b0, 4'hF, 16'h0000), M_ALL);
        cyc("rst_mid1", pk(1'b0, 1'b0, 1'b0, 4'hF, 16'h0000), M_ALL);
        reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            cyc("post_rst_idle", pk(1'b1, 1'b0, 1'b0, 4'hF, 16'h0000), M_IDLE);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
